// File: rtl/dsp_add_accum.sv
// Registered adder / accumulator with valid/ready handshake on both sides.
// S1 holds the operand beat; S2 performs the add and holds result, carry-out and accumulator.
module dsp_add_accum #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             accum,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic [WIDTH-1:0] acc
);

  localparam int unsigned Half = WIDTH / 2;
  localparam int unsigned Top  = WIDTH - Half;

  // Stage 1 operand register
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_in1_q;
  logic [WIDTH-1:0] s1_in2_q;
  logic             s1_accum_q;
  logic             s1_clear_q;

  // Stage 2 result register
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             co_q;
  logic [WIDTH-1:0] acc_q;

  logic             stall;
  logic [WIDTH-1:0] base;
  logic [Half:0]    sum_lo;
  logic [Top:0]     sum_hi;
  logic [WIDTH-1:0] sum;
  logic             sum_co;
  logic             acc_load;

  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall;

  // Split add mirrors a two-slice DSP mapping: bottom carry-out chains into the top half.
  always_comb begin
    base     = s1_in1_q;
    acc_load = s1_accum_q | s1_clear_q;
    if (s1_clear_q) begin
      base = ACC_INIT;
    end else if (s1_accum_q) begin
      base = acc_q;
    end
    sum_lo = {1'b0, base[Half-1:0]} + {1'b0, s1_in2_q[Half-1:0]};
    sum_hi = {1'b0, base[WIDTH-1:Half]} + {1'b0, s1_in2_q[WIDTH-1:Half]}
           + {{Top{1'b0}}, sum_lo[Half]};
    sum    = {sum_hi[Top-1:0], sum_lo[Half-1:0]};
    sum_co = sum_hi[Top];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_in1_q    <= '0;
      s1_in2_q    <= '0;
      s1_accum_q  <= 1'b0;
      s1_clear_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      co_q        <= 1'b0;
      acc_q       <= ACC_INIT;
    end else if (!stall) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_in1_q   <= input1;
        s1_in2_q   <= input2;
        s1_accum_q <= accum;
        s1_clear_q <= clear;
      end
      if (s1_valid_q) begin
        out_q       <= sum;
        co_q        <= sum_co;
        out_valid_q <= 1'b1;
        if (acc_load) begin
          acc_q <= sum;
        end
      end else begin
        // out/co keep the last result while idle
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign co        = co_q;
  assign acc       = acc_q;

endmodule

// File: tb/tb_dsp_add_accum.sv
// Self-checking bench for dsp_add_accum: directed scenarios plus randomized traffic
// scored against a transaction-level model of the add/accumulate rules.
module tb_dsp_add_accum;

  localparam int unsigned      W    = 32;
  localparam logic [W-1:0]     INIT = '0;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] input1;
  logic [W-1:0] input2;
  logic         accum;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         co;
  logic [W-1:0] acc;

  dsp_add_accum #(
    .WIDTH    (W),
    .ACC_INIT (INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .accum     (accum),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .co        (co),
    .acc       (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic [W-1:0] a;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         e;
  logic [W-1:0] model_acc = INIT;
  logic [W-1:0] m_base;
  logic [W:0]   m_sum;
  int           n_out = 0;

  // Every accepted beat is scored in order; each completed output beat must match the next one.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_acc = INIT;
    end else begin
      check_eq("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        n_out++;
        check_eq("out_beat_expected", 64'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("out", out, e.res);
          check_eq("co", co, e.c);
          check_eq("acc", acc, e.a);
        end
      end
      if (in_valid && in_ready) begin
        m_base = clear ? INIT : (accum ? model_acc : input1);
        m_sum  = {1'b0, m_base} + {1'b0, input2};
        if (accum || clear) model_acc = m_sum[W-1:0];
        e.res = m_sum[W-1:0];
        e.c   = m_sum[W];
        e.a   = model_acc;
        exp_q.push_back(e);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic acc_b, input logic clr_b);
    int tries = 0;
    bit done  = 0;
    in_valid = 1'b1;
    input1   = a;
    input2   = b;
    accum    = acc_b;
    clear    = clr_b;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        tries++;
        if (tries >= 50) begin
          check_eq("send_accepted", in_ready, 1);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0:       v = '1;
      1:       v = 32'h0000_FFFF;
      2:       v = '0;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  int n0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    input1    = '0;
    input2    = '0;
    accum     = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out", out, 0);
    check_eq("rst_co", co, 0);
    check_eq("rst_acc", acc, INIT);
    check_eq("rst_in_ready", in_ready, 1);

    // Plain add across the half boundary
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check_eq("add_latency", out_valid, 0);
    @(posedge clk); #1;
    check_eq("add_valid", out_valid, 1);
    check_eq("add_out", out, 32'h0001_0000);
    check_eq("add_co", co, 0);

    // Wrap-around
    send(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("wrap_out", out, 32'h0000_0001);
    check_eq("wrap_co", co, 1);
    check_eq("wrap_acc", acc, INIT);

    // Accumulate stream, input1 must be ignored
    send($urandom, 32'd5, 1'b1, 1'b1);
    send($urandom, 32'd7, 1'b1, 1'b0);
    check_eq("accs_v1", out_valid, 1);
    check_eq("accs_o1", out, 5);
    send($urandom, 32'd10, 1'b1, 1'b0);
    check_eq("accs_v2", out_valid, 1);
    check_eq("accs_o2", out, 12);
    send($urandom, 32'hFFFF_FFF0, 1'b1, 1'b0);
    check_eq("accs_v3", out_valid, 1);
    check_eq("accs_o3", out, 22);
    @(posedge clk); #1;
    check_eq("accs_v4", out_valid, 1);
    check_eq("accs_o4", out, 6);
    check_eq("accs_co", co, 1);
    check_eq("accs_acc", acc, 6);

    // Backpressure
    @(posedge clk); #1;
    n0 = n_out;
    send(1, 1, 1'b0, 1'b0);
    send(2, 2, 1'b0, 1'b0);
    check_eq("bp_first", out, 2);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    #1;
    check_eq("bp_in_ready", in_ready, 0);
    send(3, 3, 1'b0, 1'b0);
    send(4, 4, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_count", n_out - n0, 4);
    check_eq("bp_drained", exp_q.size(), 0);

    // Reset mid-stream with two beats in flight
    send(0, 5, 1'b1, 1'b1);
    send(0, 7, 1'b1, 1'b0);
    send(0, 10, 1'b1, 1'b0);
    send(1, 2, 1'b0, 1'b0);
    send(3, 4, 1'b0, 1'b0);
    check_eq("mid_acc", acc, 22);
    check_eq("mid_valid", out_valid, 1);
    reset    = 1'b1;
    in_valid = 1'b1;
    input2   = 32'd9;
    accum    = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    check_eq("mr_valid", out_valid, 0);
    check_eq("mr_acc", acc, INIT);
    check_eq("mr_co", co, 0);
    @(posedge clk); #1;
    check_eq("mr_no_ghost", out_valid, 0);
    send($urandom, 32'd3, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_eq("mr_out", out, 3);
    check_eq("mr_acc3", acc, 3);

    // Idle and hold
    send(32'h10, 32'h20, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_eq("idle_valid", out_valid, 1);
    check_eq("idle_out", out, 32'h30);
    @(posedge clk); #1;
    check_eq("hold_valid", out_valid, 0);
    check_eq("hold_out", out, 32'h30);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      input1    = rand_op();
      input2    = rand_op();
      accum     = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("final_drained", exp_q.size(), 0);
    check_eq("final_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
